sram_like_test_mem: RTL and testbench



---
 rtl/sram_like_pkg.sv | 36 +++
 rtl/sram_like_test_mem.sv | 60 ++++++
 tb/tb_sram_like_test_mem.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bus test memory.
// Size encodings and byte-lane helpers.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    m = 4'b1111;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  mask
  );
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) w[8*i +: 8] = wdata[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_like_test_mem.sv
// Behavioural single-port memory slave for the SRAM-like bus.
// One request per cycle, response exactly one cycle later.
module sram_like_test_mem
  import sram_like_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16,
  parameter int WRITABLE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] index;
  logic [3:0]            mask;
  logic [31:0]           old_word;
  logic [31:0]           write_word;
  logic                  accept;
  logic                  do_write;
  logic                  unused_addr;

  // Upper address bits alias; they are intentionally dropped.
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign index      = addr[DEPTH_LOG2+1:2];
  assign addr_ok    = req & ~rst;
  assign accept     = addr_ok;
  assign mask       = lane_mask(size, addr[1:0]);
  assign old_word   = mem[index];
  assign write_word = merge(old_word, wdata, mask);
  assign do_write   = accept & wr & (WRITABLE != 0);

  // Storage update; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[index] <= write_word;
  end

  // Registered response: full word on reads, merged word on writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ok <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      data_ok <= accept;
      if (accept) rdata <= wr ? write_word : old_word;
    end
  end

endmodule

// File: tb/tb_sram_like_test_mem.sv
// Self-checking bench for sram_like_test_mem.
// Scoreboard queues per instance, checked on the falling edge.
module tb_sram_like_test_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ram = 1'b0;
  logic        req_rom = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata_ram, rdata_rom;
  logic        addr_ok_ram, addr_ok_rom;
  logic        data_ok_ram, data_ok_rom;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t q_ram[$];
  exp_t q_rom[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  sram_like_test_mem #(.DEPTH_LOG2(16), .WRITABLE(1)) u_ram (
    .clk(clk), .rst(rst), .req(req_ram), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata_ram),
    .addr_ok(addr_ok_ram), .data_ok(data_ok_ram)
  );

  sram_like_test_mem #(.DEPTH_LOG2(10), .WRITABLE(0)) u_rom (
    .clk(clk), .rst(rst), .req(req_rom), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata_rom),
    .addr_ok(addr_ok_rom), .data_ok(data_ok_rom)
  );

  // RAM response monitor
  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (addr_ok_ram !== (req_ram & ~rst)) begin
      miscompares++;
      $display("FAIL ram_addr_ok cyc=%0d got %b want %b",
               cyc, addr_ok_ram, req_ram & ~rst);
    end
    if (data_ok_ram === 1'b1) begin
      vectors++;
      if (q_ram.size() == 0) begin
        miscompares++;
        $display("FAIL ram_unexpected_data_ok cyc=%0d rdata=%h",
                 cyc, rdata_ram);
      end else begin
        e = q_ram.pop_front();
        if (e.due != cyc || rdata_ram !== e.data) begin
          miscompares++;
          $display("FAIL ram_resp cyc=%0d got %h want %h due=%0d",
                   cyc, rdata_ram, e.data, e.due);
        end
      end
    end else if (q_ram.size() > 0 && q_ram[0].due <= cyc) begin
      vectors++;
      miscompares++;
      e = q_ram.pop_front();
      $display("FAIL ram_missing_data_ok cyc=%0d got %b want 1 data %h",
               cyc, data_ok_ram, e.data);
    end
  end

  // ROM response monitor
  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (addr_ok_rom !== (req_rom & ~rst)) begin
      miscompares++;
      $display("FAIL rom_addr_ok cyc=%0d got %b want %b",
               cyc, addr_ok_rom, req_rom & ~rst);
    end
    if (data_ok_rom === 1'b1) begin
      vectors++;
      if (q_rom.size() == 0) begin
        miscompares++;
        $display("FAIL rom_unexpected_data_ok cyc=%0d rdata=%h",
                 cyc, rdata_rom);
      end else begin
        e = q_rom.pop_front();
        if (e.due != cyc || rdata_rom !== e.data) begin
          miscompares++;
          $display("FAIL rom_resp cyc=%0d got %h want %h due=%0d",
                   cyc, rdata_rom, e.data, e.due);
        end
      end
    end else if (q_rom.size() > 0 && q_rom[0].due <= cyc) begin
      vectors++;
      miscompares++;
      e = q_rom.pop_front();
      $display("FAIL rom_missing_data_ok cyc=%0d got %b want 1 data %h",
               cyc, data_ok_rom, e.data);
    end
  end

  // Called at posedge+1; presents one request for one cycle.
  task automatic issue(input bit rom, input bit w,
                       input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ex);
    exp_t e;
    req_ram = !rom;
    req_rom = rom;
    wr = w;
    size = sz;
    addr = a;
    wdata = d;
    e.due = cyc + 1;
    e.data = ex;
    if (rom) q_rom.push_back(e);
    else q_ram.push_back(e);
    @(posedge clk);
    #1;
    req_ram = 1'b0;
    req_rom = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req_ram = 1'b1;
    req_rom = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (data_ok_ram !== 1'b0 || rdata_ram !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ram_outputs got ok=%b rdata=%h want 0/0",
               data_ok_ram, rdata_ram);
    end
    vectors++;
    if (data_ok_rom !== 1'b0 || rdata_rom !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rom_outputs got ok=%b rdata=%h want 0/0",
               data_ok_rom, rdata_rom);
    end
    vectors++;
    if (addr_ok_ram !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_addr_ok got %b want 0", addr_ok_ram);
    end
    req_ram = 1'b0;
    req_rom = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_alias_read;
    u_ram.mem[0] = 32'h3C010001;
    issue(1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0, 32'h3C010001);
    idle(2);
  endtask

  task automatic test_word_rw;
    issue(1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF);
    idle(2);
  endtask

  task automatic test_byte_half;
    exp_t e;
    u_ram.mem[32'h40] = 32'h11223344;
    req_ram = 1'b1;
    wr = 1'b1;
    size = 2'd0;
    addr = 32'h102;
    wdata = 32'hAAAAAAAA;
    e.due = cyc + 1;
    e.data = 32'h11AA3344;
    q_ram.push_back(e);
    @(negedge clk);
    vectors++;
    if (u_ram.write_word !== 32'h11AA3344) begin
      miscompares++;
      $display("FAIL byte_write_word got %h want 11aa3344",
               u_ram.write_word);
    end
    @(posedge clk);
    #1;
    size = 2'd1;
    addr = 32'h103;
    wdata = 32'h55665566;
    e.due = cyc + 1;
    e.data = 32'h55663344;
    q_ram.push_back(e);
    @(negedge clk);
    vectors++;
    if (u_ram.write_word !== 32'h55663344) begin
      miscompares++;
      $display("FAIL half_write_word got %h want 55663344",
               u_ram.write_word);
    end
    @(posedge clk);
    #1;
    req_ram = 1'b0;
    issue(1'b0, 1'b0, 2'd3, 32'h100, 32'h0, 32'h55663344);
    idle(2);
  endtask

  task automatic test_rom;
    u_rom.mem[0] = 32'h12345678;
    issue(1'b1, 1'b1, 2'd2, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 32'h12345678);
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, old, nw, a;
    logic [1:0]  sz;
    bit          sel;
    int          k;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      mdl[i] = d;
      issue(1'b0, 1'b1, 2'd2, 32'h800 + 32'(4 * i), d, d);
    end
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, 7));
      sz = 2'($urandom_range(0, 3));
      a = 32'h800 + 32'(4 * k) + 32'($urandom_range(0, 3));
      d = $urandom;
      old = mdl[k];
      nw = old;
      for (int b = 0; b < 4; b++) begin
        if (sz == 2'd0) sel = (b == int'(a[1:0]));
        else if (sz == 2'd1) sel = ((b / 2) == int'(a[1]));
        else sel = 1'b1;
        if (sel) nw[8*b +: 8] = d[8*b +: 8];
      end
      mdl[k] = nw;
      issue(1'b0, 1'b1, sz, a, d, nw);
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 1'b0, 2'($urandom_range(0, 3)),
            32'h800 + 32'(4 * i) + 32'($urandom_range(0, 3)),
            32'h0, mdl[i]);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    req_ram = 1'b1;
    wr = 1'b0;
    size = 2'd2;
    addr = 32'h100;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (rdata_ram !== 32'h0 || data_ok_ram !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got rdata=%h ok=%b want 0/0",
               rdata_ram, data_ok_ram);
    end
    vectors++;
    if (addr_ok_ram !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_addr_ok got %b want 0", addr_ok_ram);
    end
    wr = 1'b1;
    wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    vectors++;
    if (data_ok_ram !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_dropped got %b want 0", data_ok_ram);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_ram = 1'b0;
    idle(2);
    issue(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h55663344);
    idle(2);
  endtask

  initial begin
    test_reset;
    test_alias_read;
    test_word_rw;
    test_byte_half;
    test_rom;
    test_back_to_back;
    test_reset_mid;
    idle(3);
    vectors++;
    if (q_ram.size() != 0 || q_rom.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d/%0d pending want 0/0",
               q_ram.size(), q_rom.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
